// File: rtl/onchip_loader_pkg.sv
// rtl/onchip_loader_pkg.sv - shared types and helpers for the on-chip RAM stream loader
package onchip_loader_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_CNT_W     = 3;

    function automatic logic [3:0] lane_mask(input logic [LANE_CNT_W-1:0] lanes);
        case (lanes)
            3'd0:    lane_mask = 4'b0000;
            3'd1:    lane_mask = 4'b0001;
            3'd2:    lane_mask = 4'b0011;
            3'd3:    lane_mask = 4'b0111;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/onchip_mem_stream_loader_packer.sv
// rtl/onchip_mem_stream_loader_packer.sv - little-endian byte-to-word packer (stream_byte_packer)
module stream_byte_packer
    import onchip_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            data,
    output logic [LANE_CNT_W-1:0] fill_count,
    output logic [31:0]           word,
    output logic [3:0]            word_be
);

    logic [31:0]           lanes;
    logic [LANE_CNT_W-1:0] lane_cnt;

    // word/fill_count already include a byte accepted this cycle, so the top can launch the write immediately
    always_comb begin
        word       = lanes;
        fill_count = lane_cnt;
        if (accept) begin
            word[{lane_cnt[1:0], 3'b000} +: 8] = data;
            fill_count = lane_cnt + 3'd1;
        end
        word_be = lane_mask(fill_count);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (clear) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else begin
            lanes    <= word;
            lane_cnt <= fill_count;
        end
    end

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// rtl/onchip_mem_stream_loader.sv - byte stream to 1024x32 RAM write master; LOADER_CHECKSUM_EN adds a byte checksum
module onchip_mem_stream_loader
    import onchip_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_written,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    state_t                state, next_state;
    logic [ADDR_W-1:0]     address;
    logic [CNT_W-1:0]      remaining;
    logic [LANE_CNT_W-1:0] fill_count;
    logic [31:0]           word;
    logic [3:0]            word_be;
    logic                  accept, start_ok, write_fire, clear_lanes;

    assign accept      = in_valid & in_ready;
    assign start_ok    = (state == IDLE) && start;
    assign clear_lanes = (state != FILL) || abort;
    assign write_fire  = (state == FILL) && !abort &&
                         ((fill_count == 3'(BYTES_PER_WORD)) || (flush && (fill_count != '0)));
    assign mem_clken   = 1'b1;

    stream_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear_lanes),
        .accept     (accept),
        .data       (in_data),
        .fill_count (fill_count),
        .word       (word),
        .word_be    (word_be)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = (word_count == '0) ? DONE : FILL;
            FILL:  if (abort) next_state = IDLE;
                   else if (write_fire) next_state = WRITE;
            WRITE: if (abort) next_state = IDLE;
                   else next_state = (remaining == CNT_W'(1)) ? DONE : FILL;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready drops with abort so an aborted cycle never consumes a byte
    always_comb begin
        in_ready = (state == FILL) && !abort;
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address       <= '0;
            remaining     <= '0;
            words_written <= '0;
        end else if (start_ok) begin
            address       <= start_addr;
            remaining     <= word_count;
            words_written <= '0;
        end else if ((state == WRITE) && !abort) begin
            address       <= (address == ADDR_W'(DEPTH - 1)) ? '0 : address + 1'b1;
            remaining     <= remaining - 1'b1;
            words_written <= words_written + 1'b1;
        end
    end

    // Registered RAM strobes: high exactly during the WRITE state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            mem_address    <= '0;
            mem_writedata  <= '0;
        end else begin
            mem_chipselect <= write_fire;
            mem_write      <= write_fire;
            mem_byteenable <= write_fire ? word_be : 4'b0000;
            if (write_fire) begin
                mem_address   <= address;
                mem_writedata <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (accept)  checksum <= checksum + {8'h00, in_data};
    end
`endif

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// tb/tb_onchip_mem_stream_loader.sv - table-driven scoreboard bench for onchip_mem_stream_loader
module tb_onchip_mem_stream_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [10:0] word_count = '0;
    logic        abort = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [10:0] words_written;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    onchip_mem_stream_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_addr     (start_addr),
        .word_count     (word_count),
        .abort          (abort),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
`ifdef LOADER_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .mem_clken      (mem_clken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [9:0]   addr;
        logic [10:0]  cnt;
        int           nbytes;
        logic [127:0] bytes;
        bit           flush_sep;
        bit           flush_last;
        logic [10:0]  exp_ww;
    } job_t;

    wr_t  exp_q[$];
    job_t jobs[7];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mem_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h", mem_address, mem_writedata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_address), 64'(e.addr));
                chk("wr_data", 64'(mem_writedata), 64'(e.data));
                chk("wr_be", 64'(mem_byteenable), 64'(e.be));
                chk("wr_cs", 64'(mem_chipselect), 64'd1);
                chk("ready_in_write", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic model(input job_t j);
        logic [31:0] w;
        logic [9:0]  a;
        int          lanes;
        w = '0; a = j.addr; lanes = 0;
        for (int i = 0; i < j.nbytes; i++) begin
            w[8*lanes +: 8] = j.bytes[8*i +: 8];
            lanes++;
            if (lanes == 4) begin
                exp_q.push_back('{a, w, 4'hF});
                a = a + 10'd1;
                lanes = 0;
                w = '0;
            end
        end
        if ((j.flush_sep || j.flush_last) && lanes > 0)
            exp_q.push_back('{a, w, 4'((1 << lanes) - 1)});
    endtask

    task automatic pulse_start(input logic [9:0] a, input logic [10:0] n);
        start = 1'b1; start_addr = a; word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [127:0] data, input int n, input bit flush_last);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int guard;
            acc = 1'b0; guard = 0;
            in_data = data[8*i +: 8];
            in_valid = 1'b1;
            flush = flush_last && (i == n - 1);
            while (!acc && guard < 20) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: byte %0d never accepted", i);
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_idle"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input job_t j, input string name);
        model(j);
        pulse_start(j.addr, j.cnt);
        send(j.bytes, j.nbytes, j.flush_last);
        if (j.flush_sep) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        wait_done(name);
        chk({name, "_words_written"}, 64'(words_written), 64'(j.exp_ww));
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        jobs[0] = '{10'd0,    11'd2, 8,  128'h8877665544332211,   1'b0, 1'b0, 11'd2};
        jobs[1] = '{10'd1023, 11'd2, 8,  128'hA7A6A5A4A3A2A1A0,   1'b0, 1'b0, 11'd2};
        jobs[2] = '{10'd5,    11'd1, 2,  128'hBBAA,               1'b1, 1'b0, 11'd1};
        jobs[3] = '{10'd9,    11'd0, 0,  128'h0,                  1'b0, 1'b0, 11'd0};
        jobs[4] = '{10'd100,  11'd3, 11, 128'h0B0A090807060504030201, 1'b0, 1'b1, 11'd3};
        jobs[5] = '{10'd300,  11'd1, 4,  128'hCAFEF00D,           1'b0, 1'b1, 11'd1};
        jobs[6] = '{10'd7,    11'd2, 5,  128'h1004030201,         1'b1, 1'b0, 11'd2};

        #3;
        chk("rst_cs", 64'(mem_chipselect), 64'd0);
        chk("rst_write", 64'(mem_write), 64'd0);
        chk("rst_be", 64'(mem_byteenable), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_clken", 64'(mem_clken), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_ww", 64'(words_written), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer check for the first job, independent of the packing model
        chk("job0_first_word_model", 64'({jobs[0].bytes[31:24], jobs[0].bytes[23:16], jobs[0].bytes[15:8], jobs[0].bytes[7:0]}), 64'h44332211);

        for (int t = 0; t < 7; t++)
            run_job(jobs[t], $sformatf("job%0d", t));

        // abort mid-word: second start while busy must be ignored
        begin
            job_t j;
            j = '{10'd50, 11'd4, 4, 128'h44434241, 1'b0, 1'b0, 11'd1};
            model(j);
            pulse_start(10'd50, 11'd4);
            pulse_start(10'd900, 11'd0);
            send(128'h47464544434241, 7, 1'b0);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            begin
                bit saw_done;
                saw_done = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (done) saw_done = 1'b1;
                end
                chk("abort_no_done", 64'(saw_done), 64'd0);
            end
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_ww", 64'(words_written), 64'd1);
            chk("abort_queue_drained", 64'(exp_q.size()), 64'd0);
            @(posedge clk); #1;
        end

        // async reset during an in-flight write cycle
        pulse_start(10'd200, 11'd2);
        send(128'hD4D3D2D1, 4, 1'b0);
        chk("pre_reset_write_active", 64'(mem_write), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_write", 64'(mem_write), 64'd0);
        chk("async_rst_cs", 64'(mem_chipselect), 64'd0);
        chk("async_rst_be", 64'(mem_byteenable), 64'd0);
        chk("async_rst_addr", 64'(mem_address), 64'd0);
        chk("async_rst_data", 64'(mem_writedata), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_ww", 64'(words_written), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 64'(busy), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        begin
            job_t j;
            j = '{10'd600, 11'd2, 5, 128'h02FFFFFFFF, 1'b1, 1'b0, 11'd2};
            run_job(j, "csum");
            chk("checksum", 64'(checksum), 64'h03FE);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onchip_mem_stream_loader.md
Name: onchip_mem_stream_loader

Overview:
Upstream write master for the 1024x32 single-port on-chip RAM (Avalon-MM slave: 10-bit word address, 4-bit byteenable, chipselect/write, clken, no waitrequest).
Accepts a byte stream over valid/ready and packs bytes little-endian into 32-bit words. Writes each word to consecutive RAM addresses from a programmed start address for a programmed word count.
Used to load program/data images into the RAM after reset, ahead of CPU boot.

Parameters:
ADDR_W, 10, RAM word-address width; must match the RAM.
DEPTH, 1024, RAM depth in words; the address counter wraps modulo DEPTH.
CNT_W, 11, width of the word count; holds 0..DEPTH.

Ports:
clk  in  1  single clock, shared with the RAM
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches start_addr and word_count; ignored while busy
start_addr  in  ADDR_W  first RAM word address
word_count  in  CNT_W  number of words to write; 0 = immediate done
abort  in  1  drop the job; return to IDLE
in_data  in  8  stream byte
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid & in_ready
flush  in  1  write the partial word now
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
words_written  out  CNT_W  words written in the current/last job
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  4  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  32  to RAM writedata
mem_clken  out  1  to RAM clken; constant 1

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except mem_clken=1; lane count, address and counters cleared. Reset mid-job aborts with no RAM write and no done pulse.
- States:
  - IDLE: start with word_count=0 -> DONE; start with word_count>0 -> FILL (address<=start_addr, remaining<=word_count, words_written<=0).
  - FILL: in_ready=1. An accepted byte goes to lane = lane count: lane0 = [7:0] ... lane3 = [31:24].
    - On accepting lane 3 -> WRITE with byteenable 4'b1111.
    - flush with lane count>0 -> WRITE with byteenable set for the filled lanes only; unfilled lanes' writedata = 0. flush with lane count 0 is ignored.
  - WRITE: exactly one cycle with mem_chipselect=mem_write=1 and in_ready=0. Then address+1 (1023 wraps to 0), remaining-1, words_written+1, lane count cleared. Next state is DONE if remaining reaches 0, else FILL.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in FILL/WRITE/DONE.
- mem_* outputs are registered; outside WRITE, chipselect/write/byteenable are 0.
- Simultaneous in_valid and flush in FILL: the byte is accepted first, then flush applies to the resulting lane count. If that byte completes the word, a normal full write occurs and the flush is consumed.
- abort has priority over everything in FILL/WRITE:
  - any partial word is dropped; no write that cycle;
  - next state IDLE; no done pulse;
  - words_written holds its value.
- A partial flushed word counts as one word toward word_count.
- Throughput: 4 bytes per 5 cycles.
- start in IDLE only; start when not in IDLE is ignored.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: adds output checksum[15:0], the modulo-2^16 sum of every accepted byte. Cleared on an accepted start; held after done or abort; reset to 0.
- Undefined: no checksum port or logic.

Decomposition:
- Package onchip_loader_pkg:
  - state enum {IDLE, FILL, WRITE, DONE};
  - BYTES_PER_WORD=4;
  - lane-count-to-byteenable mask function (0->0000, 1->0001, 2->0011, 3->0111, 4->1111).
- Sub-module stream_byte_packer: lane register, lane counter, writedata/byteenable assembly, clear input.
- Top level holds the FSM, address/count counters and the optional checksum.

Test Plan:
- start_addr=0, word_count=2, bytes 11,22,33,44,55,66,77,88 -> writes addr0=0x44332211 be=1111 and addr1=0x88776655 be=1111; done pulse; words_written=2.
- start_addr=1023, word_count=2, 8 bytes -> writes at addr 1023 then addr 0 (wrap).
- word_count=1, bytes AA,BB then flush -> one write 0x0000BBAA be=0011; done.
- in_valid held with byte 0x10 during WRITE cycle -> in_ready=0 that cycle; byte accepted next cycle; no byte lost or duplicated.
- abort after 3 bytes of word 2 (word_count=4) -> no further writes, no done, busy=0, words_written=1; reset_n low mid-FILL -> all mem_* 0 immediately.
- LOADER_CHECKSUM_EN defined, bytes FF,FF,FF,FF,02 -> checksum=0x03FE.
